// File: rtl/roi_pkg.sv
// Shared types and default geometry for the ROI crop sequentializer.
package roi_pkg;

    localparam int unsigned DEF_BUS_W   = 256;
    localparam int unsigned DEF_PIX_W   = 8;
    localparam int unsigned DEF_IN_ROWS = 480;
    localparam int unsigned DEF_IN_COLS = 640;

    localparam int unsigned PPB   = DEF_BUS_W / DEF_PIX_W;
    localparam int unsigned COL_W = $clog2(DEF_IN_COLS);
    localparam int unsigned ROW_W = $clog2(DEF_IN_ROWS);

    // Coordinate fields are sized for the largest frame; narrower instances zero-extend.
    localparam int unsigned COORD_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
    } roi_coord_t;

endpackage

// File: rtl/roi_crop_sequentializer_if.sv
// Input beat stream and per-ROI pixel streams of the crop sequentializer.
interface roi_crop_sequentializer_if #(
    parameter int unsigned BUS_W = 256,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned N_ROI = 2
);

    logic                            s_axis_tvalid;
    logic                            s_axis_tready;
    logic [BUS_W-1:0]                s_axis_tdata;
    logic [N_ROI-1:0]                m_axis_tvalid;
    logic [N_ROI-1:0]                m_axis_tready;
    logic [N_ROI-1:0][PIX_W-1:0]     m_axis_tdata;
    logic [N_ROI-1:0]                m_axis_tlast;

    // slave: the sequentializer side (sinks beats, sources crop streams).
    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

endinterface

// File: rtl/roi_window_match.sv
// Combinational window test for one ROI, plus the coordinate clamp applied at latch time.
module roi_window_match
    import roi_pkg::*;
#(
    parameter int unsigned IN_ROWS  = 480,
    parameter int unsigned IN_COLS  = 640,
    parameter int unsigned OUT_ROWS = 48,
    parameter int unsigned OUT_COLS = 48
) (
    input  logic [$clog2(IN_COLS)-1:0] raw_x0,
    input  logic [$clog2(IN_ROWS)-1:0] raw_y0,
    input  roi_coord_t                 coord,
    input  logic [$clog2(IN_ROWS)-1:0] row,
    input  logic [$clog2(IN_COLS)-1:0] col,
    output roi_coord_t                 clamped,
    output logic                       want,
    output logic                       is_last
);

    localparam int unsigned MAX_X0 = IN_COLS - OUT_COLS;
    localparam int unsigned MAX_Y0 = IN_ROWS - OUT_ROWS;

    function automatic logic [COORD_W-1:0] clamp(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? COORD_W'(max_v) : COORD_W'(v);
    endfunction

    int unsigned x0, y0, r, c;

    always_comb begin
        x0 = 32'(coord.x0);
        y0 = 32'(coord.y0);
        r  = 32'(row);
        c  = 32'(col);
        clamped.x0 = clamp(32'(raw_x0), MAX_X0);
        clamped.y0 = clamp(32'(raw_y0), MAX_Y0);
        want    = (c >= x0) && (c < x0 + OUT_COLS) && (r >= y0) && (r < y0 + OUT_ROWS);
        is_last = (c == x0 + OUT_COLS - 1) && (r == y0 + OUT_ROWS - 1);
    end

endmodule

// File: rtl/roi_crop_sequentializer.sv
// Serialises packed pixel beats one pixel per cycle and routes each pixel to every
// crop window that contains it; one frame per ap_start.
module roi_crop_sequentializer
    import roi_pkg::*;
#(
    parameter int unsigned BUS_W    = DEF_BUS_W,
    parameter int unsigned PIX_W    = DEF_PIX_W,
    parameter int unsigned IN_ROWS  = DEF_IN_ROWS,
    parameter int unsigned IN_COLS  = DEF_IN_COLS,
    parameter int unsigned OUT_ROWS = 48,
    parameter int unsigned OUT_COLS = 48,
    parameter int unsigned N_ROI    = 2
) (
    input  logic                                 clk,
    input  logic                                 ap_rst_n,
    input  logic                                 ap_start,
    output logic                                 ap_ready,
    output logic                                 ap_idle,
    output logic                                 ap_done,
    input  logic [N_ROI-1:0][$clog2(IN_COLS)-1:0] crop_x0,
    input  logic [N_ROI-1:0][$clog2(IN_ROWS)-1:0] crop_y0,
    roi_crop_sequentializer_if.slave             axis
);

    localparam int unsigned BEAT_PIX = BUS_W / PIX_W;
    localparam int unsigned IDX_W    = (BEAT_PIX > 1) ? $clog2(BEAT_PIX) : 1;
    localparam int unsigned COL_BITS = $clog2(IN_COLS);
    localparam int unsigned ROW_BITS = $clog2(IN_ROWS);

    state_t                         state_q, state_d;
    logic                           ap_ready_q;
    logic [BEAT_PIX-1:0][PIX_W-1:0] hold_q;
    logic                           hold_valid_q;
    logic [IDX_W-1:0]               pix_idx_q;
    logic [ROW_BITS-1:0]            row_q;
    logic [COL_BITS-1:0]            col_q;
    roi_coord_t                     coord_q [N_ROI];
    roi_coord_t                     clamped [N_ROI];
    logic [N_ROI-1:0]               want, is_last;
    logic [N_ROI-1:0]               out_valid_q, out_last_q;
    logic [N_ROI-1:0][PIX_W-1:0]    out_data_q;
    logic [PIX_W-1:0]               cur_pix;
    logic advance, last_in_beat, last_col, frame_end, all_empty, start, s_fire, running;

    for (genvar k = 0; k < N_ROI; k++) begin : g_roi
        roi_window_match #(
            .IN_ROWS  (IN_ROWS),
            .IN_COLS  (IN_COLS),
            .OUT_ROWS (OUT_ROWS),
            .OUT_COLS (OUT_COLS)
        ) u_match (
            .raw_x0  (crop_x0[k]),
            .raw_y0  (crop_y0[k]),
            .coord   (coord_q[k]),
            .row     (row_q),
            .col     (col_q),
            .clamped (clamped[k]),
            .want    (want[k]),
            .is_last (is_last[k])
        );
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ap_start)  state_d = RUN;
            RUN:     if (frame_end) state_d = DONE;
            DONE:    if (all_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        all_empty = ~|out_valid_q;
        ap_idle   = (state_q == IDLE);
        running   = (state_q == RUN);
        start     = ap_idle && ap_start;
        ap_done   = (state_q == DONE) && all_empty;
    end

    // A stalled wanting channel freezes the whole stream so nothing is dropped.
    always_comb begin
        cur_pix      = hold_q[pix_idx_q];
        advance      = running && hold_valid_q && (&(~want | ~out_valid_q | axis.m_axis_tready));
        last_in_beat = (pix_idx_q == IDX_W'(BEAT_PIX - 1));
        last_col     = (col_q == COL_BITS'(IN_COLS - 1));
        frame_end    = advance && last_col && (row_q == ROW_BITS'(IN_ROWS - 1));
        axis.s_axis_tready = running && (!hold_valid_q || (last_in_beat && advance && !frame_end));
        s_fire       = axis.s_axis_tvalid && axis.s_axis_tready;
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_ready_q   <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pix_idx_q    <= '0;
            row_q        <= '0;
            col_q        <= '0;
            for (int k = 0; k < N_ROI; k++) coord_q[k] <= '0;
        end else begin
            ap_ready_q <= start;
            if (start) begin
                for (int k = 0; k < N_ROI; k++) coord_q[k] <= clamped[k];
            end
            if (s_fire) begin
                hold_q       <= axis.s_axis_tdata;
                hold_valid_q <= 1'b1;
                pix_idx_q    <= '0;
            end else if (advance) begin
                if (last_in_beat) hold_valid_q <= 1'b0;
                pix_idx_q <= pix_idx_q + 1'b1;
            end
            if (start) begin
                row_q <= '0;
                col_q <= '0;
            end else if (advance) begin
                if (last_col) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            out_data_q  <= '0;
        end else begin
            for (int k = 0; k < N_ROI; k++) begin
                if (advance && want[k]) begin
                    out_valid_q[k] <= 1'b1;
                    out_data_q[k]  <= cur_pix;
                    out_last_q[k]  <= is_last[k];
                end else if (axis.m_axis_tready[k]) begin
                    out_valid_q[k] <= 1'b0;
                end
            end
        end
    end

    assign ap_ready           = ap_ready_q;
    assign axis.m_axis_tvalid = out_valid_q;
    assign axis.m_axis_tdata  = out_data_q;
    assign axis.m_axis_tlast  = out_last_q;

endmodule
